// File: rtl/cic_interpolator.sv
// N-stage CIC interpolator, ratio R = 2^LOG2R, with ready/valid low-rate input.
// Define CIC_INTERPOLATOR_FLUSH_EN to add a synchronous flush input.
module cic_interpolator #(
  parameter  int IN_WIDTH  = 16,
  parameter  int N         = 3,
  parameter  int LOG2R     = 3,
  localparam int OUT_WIDTH = IN_WIDTH + (N-1)*LOG2R
) (
  input  logic                        clock,
  input  logic                        reset,
`ifdef CIC_INTERPOLATOR_FLUSH_EN
  input  logic                        flush,
`endif
  input  logic                        ena,
  input  logic signed [IN_WIDTH-1:0]  x_in,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [OUT_WIDTH-1:0] y_out,
  output logic                        out_valid
);

  logic [LOG2R-1:0]            phase_q, phase_d;
  logic [N-1:0][OUT_WIDTH-1:0] dly_q, dly_d;
  logic [N-1:0][OUT_WIDTH-1:0] acc_q, acc_d;
  logic                        out_valid_q, out_valid_d;
  logic [N:0][OUT_WIDTH-1:0]   comb;
  logic [OUT_WIDTH-1:0]        stuff;
  logic                        tick, accept, clr;

`ifdef CIC_INTERPOLATOR_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  // A frame only starts when a sample is offered; the remaining R-1 ticks run free.
  assign tick     = ena && (phase_q != '0 || in_valid);
  assign accept   = tick && (phase_q == '0);
  assign in_ready = ena && (phase_q == '0) && reset;

  always_comb begin
    comb[0] = OUT_WIDTH'(x_in);
    for (int j = 0; j < N; j++)
      comb[j+1] = comb[j] - dly_q[j];
    stuff = accept ? comb[N] : '0;

    phase_d     = phase_q;
    dly_d       = dly_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;

    if (clr) begin
      phase_d = '0;
      dly_d   = '0;
      acc_d   = '0;
    end else if (tick) begin
      phase_d     = phase_q + LOG2R'(1);
      out_valid_d = 1'b1;
      if (accept)
        for (int j = 0; j < N; j++)
          dly_d[j] = comb[j];
      // Every integrator sums its predecessor's previous value: one tick per stage.
      acc_d[0] = acc_q[0] + stuff;
      for (int j = 1; j < N; j++)
        acc_d[j] = acc_q[j] + acc_q[j-1];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      phase_q     <= '0;
      dly_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      dly_q       <= dly_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign y_out     = acc_q[N-1];
  assign out_valid = out_valid_q;

endmodule

// File: doc/cic_interpolator.md
CIC_INTERPOLATOR -- requirements
Module: cic_interpolator

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16: signed input sample width.
REQ-002 SHALL have parameter N, default 3: number of comb stages and number of integrator stages (1..6).
REQ-003 SHALL have parameter LOG2R, default 3: interpolation ratio R = 2^LOG2R (1..6); differential delay fixed at 1.
REQ-004 SHALL derive localparam OUT_WIDTH = IN_WIDTH + (N-1)*LOG2R, the internal and output width.
REQ-005 SHALL have port: clock  in  1  single clock, all logic on rising edge.
REQ-006 SHALL have port: reset  in  1  synchronous, active-low reset, sampled on rising clock.
REQ-007 SHALL have port: ena  in  1  clock enable; no tick occurs while low.
REQ-008 SHALL have port: x_in  in  IN_WIDTH  signed low-rate sample.
REQ-009 SHALL have port: in_valid  in  1  x_in holds a sample.
REQ-010 SHALL have port: in_ready  out  1  block accepts x_in this cycle.
REQ-011 SHALL have port: y_out  out  OUT_WIDTH  signed high-rate sample, registered.
REQ-012 SHALL have port: out_valid  out  1  y_out updated by the tick in the previous cycle.

Function
REQ-013 SHALL keep a phase counter 0..R-1; in_ready = ena && phase==0 && reset high (combinational).
REQ-014 SHALL define tick = ena && (phase!=0 || in_valid); accept = tick && phase==0.
REQ-015 On tick, phase SHALL advance by 1, wrapping R-1 -> 0; with no tick, phase and all datapath state SHALL hold.
REQ-016 Comb chain SHALL be combinational from sign-extended x_in: c0 = x_in, cj = c(j-1) - dj; each delay dj SHALL load c(j-1) only on accept.
REQ-017 Zero-stuffer SHALL present cN on accept and 0 on every other tick.
REQ-018 Integrators SHALL be a registered chain updated on every tick: a1 <= a1 + stuff, aj <= aj + a(j-1); y_out = aN.
REQ-019 All arithmetic SHALL be OUT_WIDTH two's complement, wrapping modulo 2^OUT_WIDTH without saturation.
REQ-020 out_valid SHALL be registered: 1 in the cycle after a tick, else 0.
REQ-021 An input accepted on tick T SHALL first affect y_out after tick T+N-1 (N ticks counting T).
REQ-022 Steady DC input x SHALL yield y_out = x * R^(N-1) after settling.
REQ-023 When phase==0 with in_valid low, the block SHALL stall (no tick, out_valid 0, state held); in_valid during phase!=0 SHALL be ignored.

Reset
REQ-024 While reset is low at a rising edge, phase, all dj, all aj, y_out and out_valid SHALL clear to 0.
REQ-025 Reset mid-frame SHALL discard the partial frame; the first accept after release SHALL occur at phase 0.
REQ-026 in_ready SHALL be 0 while reset is low.

Configuration
REQ-027 With macro CIC_INTERPOLATOR_FLUSH_EN defined, an input port flush (1 bit) SHALL exist; flush high at a rising edge SHALL clear the same state as REQ-024, priority below reset and above tick.
REQ-028 Without CIC_INTERPOLATOR_FLUSH_EN, the flush port SHALL not exist and behaviour SHALL be otherwise identical.

Verification
REQ-029 N=1, LOG2R=2, ena=1, in_valid=1, inputs 1 then 0s -> y_out sequence 1,1,1,1,0,0,... with out_valid high every cycle.
REQ-030 Defaults, constant x_in=100 -> y_out settles to 6400; constant x_in=-32768 -> settles to -2097152.
REQ-031 Defaults, in_valid low at phase 0 for 5 cycles -> in_ready 1, out_valid 0, y_out held; raise in_valid -> accept and resume.
REQ-032 Defaults, reset low at phase 4 -> next cycle y_out=0, out_valid=0, in_ready=0; after release first accept at phase 0.
REQ-033 Defaults, ena low for 3 cycles mid-frame -> phase, y_out held, out_valid 0; in_ready 0.
REQ-034 With CIC_INTERPOLATOR_FLUSH_EN, flush at phase 5 after DC 100 -> y_out=0, phase 0, next DC settles to 6400 again.
